// File: rtl/auth_initiator.sv
// Authentication initiator: builds a GET_DIGESTS / GET_CERTIFICATE / CHALLENGE request,
// hands it to the USB transport, waits for the response with timeout and retries, then checks the header.
module auth_initiator #(
    parameter int MSG_LEN           = 512,
    parameter int HDR_W             = 32,
    parameter int DIGEST_TIMEOUT    = 1000,
    parameter int CERT_TIMEOUT      = 1000,
    parameter int CHALLENGE_TIMEOUT = 2000,
    parameter int MAX_RETRIES       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               req_type,
    input  logic [7:0]               req_param1,
    input  logic [7:0]               req_param2,
    input  logic [MSG_LEN-HDR_W-1:0] req_payload,
    output logic                     init_req_out,
    output logic [MSG_LEN-1:0]       init_msg_out,
    output logic [7:0]               bmRequestType,
    output logic [7:0]               bRequest,
    output logic [15:0]              wLength,
    input  logic                     tx_ack,
    input  logic                     resp_valid_in,
    input  logic [MSG_LEN-1:0]       resp_msg_in,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               status,
    output logic [HDR_W-1:0]         resp_header,
    output logic [MSG_LEN-HDR_W-1:0] resp_payload
);

    localparam int PAY_W   = MSG_LEN - HDR_W;
    localparam int MAX_TO  = (DIGEST_TIMEOUT > CERT_TIMEOUT)
                           ? ((DIGEST_TIMEOUT > CHALLENGE_TIMEOUT) ? DIGEST_TIMEOUT : CHALLENGE_TIMEOUT)
                           : ((CERT_TIMEOUT > CHALLENGE_TIMEOUT) ? CERT_TIMEOUT : CHALLENGE_TIMEOUT);
    localparam int CNT_W   = $clog2(MAX_TO + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_ERROR_RESP = 3'd1;
    localparam logic [2:0] ST_TIMEOUT    = 3'd2;
    localparam logic [2:0] ST_BAD_VER    = 3'd3;
    localparam logic [2:0] ST_UNEXPECTED = 3'd4;
    localparam logic [2:0] ST_ILLEGAL    = 3'd5;

    typedef enum logic [6:0] {
        IDLE      = 7'b0000001,
        BUILD     = 7'b0000010,
        SEND      = 7'b0000100,
        WAIT_RESP = 7'b0001000,
        CHECK     = 7'b0010000,
        RETRY     = 7'b0100000,
        DONE      = 7'b1000000
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           type_q;
    logic [7:0]           param1_q;
    logic [7:0]           param2_q;
    logic [PAY_W-1:0]     payload_q;
    logic [CNT_W-1:0]     tmo_cnt;
    logic [CNT_W-1:0]     tmo_limit;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 tmo_expired;
    logic                 retry_left;

    function automatic logic [7:0] msg_type(input logic [1:0] t);
        case (t)
            2'd0:    return 8'h81;
            2'd1:    return 8'h82;
            2'd2:    return 8'h83;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] setup_len(input logic [1:0] t);
        case (t)
            2'd0:    return 16'd4;
            2'd1:    return 16'd8;
            2'd2:    return 16'd36;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] timeout_of(input logic [1:0] t);
        case (t)
            2'd0:    return CNT_W'(DIGEST_TIMEOUT);
            2'd1:    return CNT_W'(CERT_TIMEOUT);
            default: return CNT_W'(CHALLENGE_TIMEOUT);
        endcase
    endfunction

    // Responses carry the request MessageType with bit 7 cleared; 0x7F is the ERROR message.
    function automatic logic [2:0] check_header(input logic [HDR_W-1:0] hdr, input logic [7:0] req_mt);
        if (hdr[HDR_W-1 -: 8] != 8'h01)
            return ST_BAD_VER;
        else if (hdr[HDR_W-9 -: 8] == 8'h7F)
            return ST_ERROR_RESP;
        else if (hdr[HDR_W-9 -: 8] == (req_mt & 8'h7F))
            return ST_OK;
        else
            return ST_UNEXPECTED;
    endfunction

    assign tmo_expired = (tmo_cnt == tmo_limit - CNT_W'(1));
    assign retry_left  = (retry_cnt < RETRY_W'(MAX_RETRIES));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = BUILD;
            BUILD:     state_next = (type_q == 2'd3) ? DONE : SEND;
            SEND:      if (tx_ack) state_next = WAIT_RESP;
            WAIT_RESP: begin
                // A response in the expiry cycle still counts.
                if (resp_valid_in)
                    state_next = CHECK;
                else if (tmo_expired)
                    state_next = RETRY;
            end
            CHECK:     state_next = DONE;
            RETRY:     state_next = retry_left ? SEND : DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            type_q        <= '0;
            param1_q      <= '0;
            param2_q      <= '0;
            payload_q     <= '0;
            tmo_cnt       <= '0;
            tmo_limit     <= '0;
            retry_cnt     <= '0;
            init_req_out  <= 1'b0;
            init_msg_out  <= '0;
            bmRequestType <= '0;
            bRequest      <= '0;
            wLength       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            status        <= '0;
            resp_header   <= '0;
            resp_payload  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        type_q       <= req_type;
                        param1_q     <= req_param1;
                        param2_q     <= req_param2;
                        payload_q    <= req_payload;
                        busy         <= 1'b1;
                        status       <= ST_OK;
                        resp_header  <= '0;
                        resp_payload <= '0;
                    end
                end
                BUILD: begin
                    if (type_q == 2'd3) begin
                        status <= ST_ILLEGAL;
                        done   <= 1'b1;
                    end else begin
                        init_msg_out  <= {8'h01, msg_type(type_q), param1_q, param2_q, payload_q};
                        bmRequestType <= 8'h00;
                        bRequest      <= 8'd25;
                        wLength       <= setup_len(type_q);
                        tmo_limit     <= timeout_of(type_q);
                        retry_cnt     <= '0;
                        init_req_out  <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_ack) begin
                        init_req_out <= 1'b0;
                        tmo_cnt      <= '0;
                    end
                end
                WAIT_RESP: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (resp_valid_in) begin
                        resp_header  <= resp_msg_in[MSG_LEN-1 -: HDR_W];
                        resp_payload <= resp_msg_in[PAY_W-1:0];
                    end
                end
                CHECK: begin
                    status <= check_header(resp_header, msg_type(type_q));
                    done   <= 1'b1;
                end
                RETRY: begin
                    // Resend the message already held on init_msg_out.
                    if (retry_left) begin
                        retry_cnt    <= retry_cnt + RETRY_W'(1);
                        init_req_out <= 1'b1;
                    end else begin
                        status <= ST_TIMEOUT;
                        done   <= 1'b1;
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_auth_initiator.sv
// Self-checking bench for auth_initiator: directed scenarios plus randomized requests
// checked against a transaction-level model of the request/response protocol.
module tb_auth_initiator;

    localparam int MSG_LEN     = 512;
    localparam int HDR_W       = 32;
    localparam int PAY_W       = MSG_LEN - HDR_W;
    localparam int DIG_TO      = 20;
    localparam int CERT_TO     = 30;
    localparam int CHAL_TO     = 40;
    localparam int MAX_RETRIES = 2;

    logic               clk;
    logic               reset;
    logic               start;
    logic [1:0]         req_type;
    logic [7:0]         req_param1;
    logic [7:0]         req_param2;
    logic [PAY_W-1:0]   req_payload;
    logic               init_req_out;
    logic [MSG_LEN-1:0] init_msg_out;
    logic [7:0]         bmRequestType;
    logic [7:0]         bRequest;
    logic [15:0]        wLength;
    logic               tx_ack;
    logic               resp_valid_in;
    logic [MSG_LEN-1:0] resp_msg_in;
    logic               busy;
    logic               done;
    logic [2:0]         status;
    logic [HDR_W-1:0]   resp_header;
    logic [PAY_W-1:0]   resp_payload;

    int n_checks = 0;
    int n_pass   = 0;

    // observations from the last run_request
    int                 o_sends;
    int                 o_cycles;
    bit                 o_done;
    bit                 o_stable;
    bit                 o_busy_after;
    bit                 o_done_after;
    logic [MSG_LEN-1:0] o_msg;
    logic [15:0]        o_wlen;
    logic [7:0]         o_bm;
    logic [7:0]         o_breq;

    // model predictions
    logic [2:0] e_status;
    int         e_sends;
    int         e_cycles;
    bit         e_got;

    auth_initiator #(
        .MSG_LEN(MSG_LEN), .HDR_W(HDR_W), .DIGEST_TIMEOUT(DIG_TO), .CERT_TIMEOUT(CERT_TO),
        .CHALLENGE_TIMEOUT(CHAL_TO), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .req_type(req_type),
        .req_param1(req_param1), .req_param2(req_param2), .req_payload(req_payload),
        .init_req_out(init_req_out), .init_msg_out(init_msg_out),
        .bmRequestType(bmRequestType), .bRequest(bRequest), .wLength(wLength),
        .tx_ack(tx_ack), .resp_valid_in(resp_valid_in), .resp_msg_in(resp_msg_in),
        .busy(busy), .done(done), .status(status),
        .resp_header(resp_header), .resp_payload(resp_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int limit_of(input logic [1:0] t);
        case (t)
            2'd0:    return DIG_TO;
            2'd1:    return CERT_TO;
            default: return CHAL_TO;
        endcase
    endfunction

    function automatic logic [7:0] mt_of(input logic [1:0] t);
        return 8'h81 + {6'd0, t};
    endfunction

    function automatic logic [15:0] wlen_of(input logic [1:0] t);
        case (t)
            2'd0:    return 16'd4;
            2'd1:    return 16'd8;
            default: return 16'd36;
        endcase
    endfunction

    function automatic logic [2:0] model_status(input logic [31:0] hdr, input logic [1:0] t);
        if (hdr[31:24] != 8'h01) return 3'd3;
        if (hdr[23:16] == 8'h7F) return 3'd1;
        if (hdr[23:16] == (mt_of(t) & 8'h7F)) return 3'd0;
        return 3'd4;
    endfunction

    // Cycle counts are taken from the start-sampling edge to the edge that raises done.
    // One attempt costs SEND (1+ack) + WAIT (limit) + RETRY (1).
    task automatic predict(input logic [1:0] t, input int ack, input int att, input int dly,
                           input logic [31:0] hdr);
        int p;
        p = limit_of(t) + 2 + ack;
        if (t == 2'd3) begin
            e_status = 3'd5; e_sends = 0; e_cycles = 2; e_got = 0;
        end else if (att >= 0 && att <= MAX_RETRIES && dly <= limit_of(t) - 1) begin
            e_status = model_status(hdr, t); e_sends = att + 1;
            e_cycles = 5 + att * p + ack + dly; e_got = 1;
        end else begin
            e_status = 3'd2; e_sends = MAX_RETRIES + 1;
            e_cycles = 2 + (MAX_RETRIES + 1) * p; e_got = 0;
        end
    endtask

    // Drives one command and plays the transport: acks after 'ack' cycles of SEND and
    // answers on attempt 'att' after 'dly' wait cycles. 'stray' adds a start and a
    // response pulse while the block is busy outside WAIT_RESP.
    task automatic run_request(input logic [1:0] t, input logic [7:0] p1, input logic [7:0] p2,
                               input logic [PAY_W-1:0] pay, input int ack, input int att,
                               input int dly, input logic [MSG_LEN-1:0] resp, input bit stray);
        int  ack_cnt;
        int  wait_k;
        int  attempt;
        bit  in_wait;
        bit  prev_req;
        ack_cnt = 0; wait_k = 0; attempt = -1; in_wait = 0; prev_req = 0;
        o_sends = 0; o_cycles = 0; o_done = 0; o_stable = 1;
        o_msg = '0; o_wlen = '0; o_bm = '0; o_breq = '0;
        @(negedge clk);
        req_type = t; req_param1 = p1; req_param2 = p2; req_payload = pay; start = 1'b1;
        while (!o_done && o_cycles < 1000) begin
            @(negedge clk);
            o_cycles++;
            start = 1'b0; tx_ack = 1'b0; resp_valid_in = 1'b0;
            if (stray && o_cycles == 4) begin
                start = 1'b1; req_type = 2'd3; req_param1 = ~p1;
            end
            if (done) begin
                o_done = 1;
            end else if (init_req_out) begin
                if (!prev_req) begin
                    o_sends++; attempt++; ack_cnt = 0; in_wait = 0;
                    if (o_sends == 1) begin
                        o_msg = init_msg_out; o_wlen = wLength; o_bm = bmRequestType; o_breq = bRequest;
                    end
                end
                if (init_msg_out !== o_msg) o_stable = 0;
                if (stray) begin
                    resp_valid_in = 1'b1;
                    resp_msg_in = {8'h02, 8'h7F, 16'hDEAD, {PAY_W{1'b1}}};
                end
                if (ack_cnt == ack) begin
                    tx_ack = 1'b1; in_wait = 1; wait_k = 0;
                end else begin
                    ack_cnt++;
                end
            end else if (in_wait) begin
                if (attempt == att && wait_k == dly) begin
                    resp_valid_in = 1'b1; resp_msg_in = resp;
                end
                wait_k++;
            end
            prev_req = init_req_out;
        end
        start = 1'b0; tx_ack = 1'b0; resp_valid_in = 1'b0;
        @(negedge clk);
        o_busy_after = busy; o_done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || init_req_out !== 1'b0)
            $display("FAIL reset_ctrl: busy=%b done=%b req=%b want 0", busy, done, init_req_out); else n_pass++;
        n_checks++; if (status !== 3'd0 || resp_header !== '0 || resp_payload !== '0)
            $display("FAIL reset_resp: status=%0d hdr=%h want 0", status, resp_header); else n_pass++;
        n_checks++; if (init_msg_out !== '0 || wLength !== 16'd0 || bRequest !== 8'd0 || bmRequestType !== 8'd0)
            $display("FAIL reset_setup: wLength=%0d bRequest=%0d want 0", wLength, bRequest); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_digests_ok();
        logic [PAY_W-1:0] body;
        for (int i = 0; i < PAY_W / 32; i++) body[i*32 +: 32] = $urandom();
        predict(2'd0, 0, 0, 10, 32'h01010001);
        run_request(2'd0, 8'h00, 8'h00, '0, 0, 0, 10, {32'h01010001, body}, 0);
        n_checks++; if (o_msg[MSG_LEN-1 -: 32] !== 32'h01810000)
            $display("FAIL dig_header: got %h want 01810000", o_msg[MSG_LEN-1 -: 32]); else n_pass++;
        n_checks++; if (o_bm !== 8'h00 || o_breq !== 8'd25 || o_wlen !== 16'd4)
            $display("FAIL dig_setup: bm=%h bReq=%0d wLen=%0d want 00/25/4", o_bm, o_breq, o_wlen); else n_pass++;
        n_checks++; if (!o_done || o_cycles !== e_cycles)
            $display("FAIL dig_latency: done=%b cycles=%0d want %0d", o_done, o_cycles, e_cycles); else n_pass++;
        n_checks++; if (status !== 3'd0 || resp_header !== 32'h01010001 || resp_payload !== body)
            $display("FAIL dig_status: status=%0d hdr=%h want 0/01010001", status, resp_header); else n_pass++;
        n_checks++; if (o_busy_after !== 1'b0 || o_done_after !== 1'b0)
            $display("FAIL dig_done_pulse: busy=%b done=%b after done, want 0/0", o_busy_after, o_done_after); else n_pass++;
    endtask

    task automatic test_challenge();
        logic [PAY_W-1:0] nonce;
        nonce = '0;
        for (int i = 0; i < 8; i++) nonce[i*32 +: 32] = 32'hA5A5A5A5;
        run_request(2'd2, 8'h03, 8'h00, nonce, 1, 0, 5, {32'h01030000, {PAY_W{1'b0}}}, 0);
        n_checks++; if (o_wlen !== 16'd36 || o_msg[PAY_W-1:0] !== nonce)
            $display("FAIL chal_msg: wLength=%0d payload_lsw=%h want 36/a5a5a5a5", o_wlen, o_msg[31:0]); else n_pass++;
        n_checks++; if (o_msg[MSG_LEN-1 -: 32] !== 32'h01830300)
            $display("FAIL chal_header: got %h want 01830300", o_msg[MSG_LEN-1 -: 32]); else n_pass++;
        n_checks++; if (status !== 3'd0)
            $display("FAIL chal_status: got %0d want 0", status); else n_pass++;
    endtask

    task automatic test_error_resp();
        run_request(2'd1, 8'h01, 8'h00, '0, 0, 0, 3, {32'h017F0600, {PAY_W{1'b0}}}, 0);
        n_checks++; if (status !== 3'd1 || resp_header[15:8] !== 8'h06)
            $display("FAIL err_resp: status=%0d code=%h want 1/06", status, resp_header[15:8]); else n_pass++;
        n_checks++; if (o_wlen !== 16'd8)
            $display("FAIL cert_wlen: got %0d want 8", o_wlen); else n_pass++;
    endtask

    task automatic test_timeout();
        predict(2'd0, 0, -1, 0, 32'h0);
        run_request(2'd0, 8'h00, 8'h00, '0, 0, -1, 0, '0, 0);
        n_checks++; if (o_sends !== 3 || !o_stable)
            $display("FAIL tmo_sends: sends=%0d stable=%b want 3/1", o_sends, o_stable); else n_pass++;
        n_checks++; if (status !== 3'd2 || o_cycles !== e_cycles)
            $display("FAIL tmo_status: status=%0d cycles=%0d want 2/%0d", status, o_cycles, e_cycles); else n_pass++;
        predict(2'd0, 0, 2, DIG_TO - 1, 32'h01010000);
        run_request(2'd0, 8'h00, 8'h00, '0, 0, 2, DIG_TO - 1, {32'h01010000, {PAY_W{1'b0}}}, 0);
        n_checks++; if (status !== 3'd0 || o_sends !== 3 || o_cycles !== e_cycles)
            $display("FAIL tmo_last_cycle: status=%0d sends=%0d cycles=%0d want 0/3/%0d",
                     status, o_sends, o_cycles, e_cycles); else n_pass++;
    endtask

    task automatic test_bad_header();
        run_request(2'd0, 8'h00, 8'h00, '0, 0, 0, 2, {32'h02010000, {PAY_W{1'b0}}}, 0);
        n_checks++; if (status !== 3'd3)
            $display("FAIL bad_version: got %0d want 3", status); else n_pass++;
        run_request(2'd0, 8'h00, 8'h00, '0, 0, 0, 2, {32'h01020000, {PAY_W{1'b0}}}, 0);
        n_checks++; if (status !== 3'd4)
            $display("FAIL unexpected_type: got %0d want 4", status); else n_pass++;
        run_request(2'd3, 8'h00, 8'h00, '0, 0, 0, 2, '0, 0);
        n_checks++; if (status !== 3'd5 || o_sends !== 0 || !o_done)
            $display("FAIL illegal_req: status=%0d sends=%0d done=%b want 5/0/1", status, o_sends, o_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        predict(2'd1, 2, 0, 4, 32'h01020000);
        run_request(2'd1, 8'h02, 8'h00, '0, 2, 0, 4, {32'h01020000, {PAY_W{1'b0}}}, 1);
        n_checks++; if (status !== 3'd0 || o_sends !== 1 || o_cycles !== e_cycles)
            $display("FAIL busy_start_drop: status=%0d sends=%0d cycles=%0d want 0/1/%0d",
                     status, o_sends, o_cycles, e_cycles); else n_pass++;
        run_request(2'd0, 8'h07, 8'h01, '0, 0, 0, 0, {32'h01010000, {PAY_W{1'b0}}}, 0);
        n_checks++; if (status !== 3'd0 || o_msg[MSG_LEN-1 -: 32] !== 32'h01810701)
            $display("FAIL back_to_back: status=%0d header=%h want 0/01810701", status, o_msg[MSG_LEN-1 -: 32]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 0;
        @(negedge clk);
        req_type = 2'd1; req_param1 = 8'h05; req_param2 = 8'h00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        n_checks++; if (init_req_out !== 1'b1)
            $display("FAIL mid_send: init_req_out=%b want 1", init_req_out); else n_pass++;
        tx_ack = 1'b1;
        @(negedge clk); tx_ack = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || init_req_out !== 1'b0 || wLength !== 16'd0 || init_msg_out !== '0 || status !== 3'd0)
            $display("FAIL mid_reset_outputs: busy=%b req=%b wLength=%0d status=%0d want 0",
                     busy, init_req_out, wLength, status); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            resp_valid_in = (i == 2);
            resp_msg_in = {32'h01020000, {PAY_W{1'b0}}};
            @(negedge clk);
            if (done || busy || init_req_out) bad = 1;
        end
        resp_valid_in = 1'b0;
        n_checks++; if (bad)
            $display("FAIL mid_reset_no_done: activity after reset, want none"); else n_pass++;
        n_checks++; if (resp_header !== 32'h0)
            $display("FAIL idle_resp_drop: resp_header=%h want 00000000", resp_header); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [1:0]         t;
            logic [7:0]         p1;
            logic [7:0]         p2;
            logic [PAY_W-1:0]   pay;
            logic [PAY_W-1:0]   body;
            logic [31:0]        hdr;
            int                 ack;
            int                 att;
            int                 dly;
            t = 2'($urandom_range(0, 3));
            p1 = 8'($urandom()); p2 = 8'($urandom());
            for (int i = 0; i < PAY_W / 32; i++) begin
                pay[i*32 +: 32] = $urandom(); body[i*32 +: 32] = $urandom();
            end
            ack = $urandom_range(0, 3);
            att = $urandom_range(0, MAX_RETRIES + 1);
            dly = $urandom_range(0, limit_of(t));
            case ($urandom_range(0, 3))
                0:       hdr = {8'h01, mt_of(t) & 8'h7F, 16'($urandom())};
                1:       hdr = {8'h01, 8'h7F, 16'($urandom())};
                2:       hdr = {8'($urandom_range(2, 255)), 24'($urandom())};
                default: hdr = {8'h01, 8'($urandom()), 16'($urandom())};
            endcase
            predict(t, ack, att, dly, hdr);
            run_request(t, p1, p2, pay, ack, att, dly, {hdr, body}, 0);
            n_checks++; if (status !== e_status || o_sends !== e_sends)
                $display("FAIL rnd%0d_status: type=%0d status=%0d sends=%0d want %0d/%0d",
                         n, t, status, o_sends, e_status, e_sends); else n_pass++;
            n_checks++; if (!o_done || o_cycles !== e_cycles || o_busy_after !== 1'b0)
                $display("FAIL rnd%0d_timing: done=%b cycles=%0d busy_after=%b want 1/%0d/0",
                         n, o_done, o_cycles, o_busy_after, e_cycles); else n_pass++;
            if (t != 2'd3) begin
                n_checks++; if (o_msg !== {8'h01, mt_of(t), p1, p2, pay} || !o_stable || o_wlen !== wlen_of(t))
                    $display("FAIL rnd%0d_msg: header=%h stable=%b wLength=%0d want %h/1/%0d",
                             n, o_msg[MSG_LEN-1 -: 32], o_stable, o_wlen, {8'h01, mt_of(t), p1, p2}, wlen_of(t)); else n_pass++;
            end
            if (e_got) begin
                n_checks++; if (resp_header !== hdr || resp_payload !== body)
                    $display("FAIL rnd%0d_capture: hdr=%h want %h", n, resp_header, hdr); else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req_type = '0; req_param1 = '0; req_param2 = '0;
        req_payload = '0; tx_ack = 1'b0; resp_valid_in = 1'b0; resp_msg_in = '0;
        test_reset();
        test_digests_ok();
        test_challenge();
        test_error_resp();
        test_timeout();
        test_bad_header();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/auth_initiator.md
Name: auth_initiator

Overview:
- Authentication initiator for the USB Type-C authentication driver. It is the requesting end of the protocol served by the on-chip authentication responder.
- Builds one GET_DIGESTS, GET_CERTIFICATE or CHALLENGE request from a host-side command and hands it to the USB transport with control-transfer fields.
- Waits for the response under a per-request timeout, with bounded retries, then validates the response header and reports status.

Parameters:
- MSG_LEN, 512: total message width in bits, header included.
- HDR_W, 32: header width in bits. Four 8-bit fields: ProtocolVersion, MessageType, Param1, Param2, MSB first.
- DIGEST_TIMEOUT, 1000: clock cycles allowed for a DIGESTS response.
- CERT_TIMEOUT, 1000: clock cycles allowed for a CERTIFICATE response.
- CHALLENGE_TIMEOUT, 2000: clock cycles allowed for a CHALLENGE_AUTH response.
- MAX_RETRIES, 2: resends after the first timeout before giving up.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  command pulse; sampled in IDLE only
- req_type  in  2  0=GET_DIGESTS, 1=GET_CERTIFICATE, 2=CHALLENGE, 3=illegal
- req_param1  in  8  Param1 of the request (slot number)
- req_param2  in  8  Param2 of the request
- req_payload  in  MSG_LEN-HDR_W  request body (offset/length or 256-bit nonce), LSB-aligned
- init_req_out  out  1  request valid to transport
- init_msg_out  out  MSG_LEN  request message
- bmRequestType  out  8  USB setup field
- bRequest  out  8  USB setup field
- wLength  out  16  USB setup field
- tx_ack  in  1  transport accepted the request
- resp_valid_in  in  1  response message valid, one-cycle pulse
- resp_msg_in  in  MSG_LEN  response message
- busy  out  1  high from the start accept until DONE
- done  out  1  one-cycle completion pulse
- status  out  3  0=OK, 1=ERROR_RESP, 2=TIMEOUT, 3=BAD_VERSION, 4=UNEXPECTED_TYPE, 5=ILLEGAL_REQ
- resp_header  out  HDR_W  captured response header
- resp_payload  out  MSG_LEN-HDR_W  captured response body

Behaviour:
- Reset, in any state including mid-transfer:
  - State goes to IDLE.
  - All outputs go to 0; retry and timeout counters cleared.
  - An in-flight request is abandoned and no done pulse is issued.
- State machine (one-hot): IDLE, BUILD, SEND, WAIT_RESP, CHECK, RETRY, DONE.
- IDLE:
  - On start=1, latch req_type, req_param1, req_param2 and req_payload; set busy=1; go to BUILD.
  - With start=0, stay in IDLE.
- BUILD (1 cycle):
  - Header = {8'h01, MessageType, param1, param2}.
  - MessageType 0x81/0x82/0x83 for req_type 0/1/2.
  - bmRequestType=8'h00, bRequest=8'd25.
  - wLength = 4 for digests, 8 for certificate, 36 for challenge.
  - Load the timeout limit for the request type; clear retry_cnt; go to SEND.
  - req_type=3: status=5, go to DONE; nothing is sent.
- SEND:
  - init_req_out=1, with init_msg_out held stable until tx_ack=1.
  - tx_ack in the same cycle ends SEND: init_req_out=0 on the next cycle, timeout counter cleared, go to WAIT_RESP.
- WAIT_RESP:
  - The counter increments every cycle.
  - resp_valid_in=1: capture resp_header/resp_payload, go to CHECK.
  - Counter reaches limit-1 with no response: go to RETRY.
  - Response and timeout in the same cycle: the response wins.
- RETRY:
  - retry_cnt < MAX_RETRIES: increment retry_cnt, go to SEND with the identical message.
  - Otherwise: status=2, go to DONE.
- CHECK (1 cycle):
  - ProtocolVersion != 1: status=3.
  - Else MessageType == 0x7F: status=1; the error code is readable in resp_header Param1.
  - Else MessageType == request MessageType & 0x7F (0x01/0x02/0x03): status=0.
  - Else: status=4.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0 on the next cycle, return to IDLE.
- Output hold: status, resp_header and resp_payload hold until the next accepted start.
- Ignored inputs:
  - resp_valid_in outside WAIT_RESP is dropped.
  - start while busy is dropped.
- Output registers: all outputs are registered on posedge clk; the block uses no negedge logic.

Test Plan:
- Digests OK: start, req_type=0, param1=0 → init_msg_out header 32'h01810000, bmRequestType=0, bRequest=25, wLength=4. Then tx_ack, resp header 32'h01010001 after 10 cycles → done pulse, status=0, resp_header=32'h01010001.
- Challenge with nonce=256'hA5..A5 → wLength=36, payload equals nonce. Then resp header 32'h01030000 → status=0.
- Error response: certificate request, response header 32'h017F0600 → status=1, resp_header[15:8]=8'h06.
- Timeout with retries: DIGEST_TIMEOUT=20, MAX_RETRIES=2, no response → three SEND phases, done at about 60 cycles plus the ack cycles, status=2. Response arriving on the final counter cycle → status=0.
- Bad header: response 32'h02010000 → status=3. Response 32'h01020000 to a digests request → status=4. req_type=3 → no init_req_out, status=5.
- Robustness:
  - reset asserted during WAIT_RESP → IDLE next cycle, all outputs 0, no done.
  - start pulsed during busy → ignored.
  - resp_valid_in in IDLE → ignored.
